fifo_sync_level: RTL and testbench
==================================

// Module: fifo_sync_level
// PURPOSE
//   Parametrised single-clock FIFO with an occupancy count, almost-full and almost-empty
//   watermarks, and a registered read port. It is the next generation of the TT FIFO
//   datapath and replaces the divided-clock, 4-bit, 8-deep instance.
//   It sits between ui_in capture logic and the uo_out register stage in tt_um_* tops.
// PARAMETERS
//   DATA_WIDTH     4   payload width in bits
//   ADDR_WIDTH     3   log2(depth); DEPTH = 2**ADDR_WIDTH
//   AFULL_THRESH   6   almost_full when count >= AFULL_THRESH  (1..DEPTH)
//   AEMPTY_THRESH  1   almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
// PORTS
//   clk           in   1             sole clock, rising edge
//   rst_n         in   1             asynchronous, active-low reset
//   winc          in   1             write request
//   wdata         in   DATA_WIDTH    write payload
//   rinc          in   1             read request
//   rdata         out  DATA_WIDTH    read payload, registered
//   rvalid        out  1             rdata holds a word popped on the previous edge
//   full          out  1             count == DEPTH
//   empty         out  1             count == 0
//   almost_full   out  1             count >= AFULL_THRESH
//   almost_empty  out  1             count <= AEMPTY_THRESH
//   count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   overflow      out  1             sticky write-when-full flag (FIFO_ERR_FLAGS_EN only)
//   underflow     out  1             sticky read-when-empty flag (FIFO_ERR_FLAGS_EN only)
// BEHAVIOUR
//   - Reset (async, rst_n=0): wptr=rptr=0, count=0, rdata=0, rvalid=0, overflow=underflow=0.
//     Outputs during reset: empty=1, full=0, almost_empty=1, almost_full=0.
//     Reset asserted mid-operation discards all contents immediately. Memory is not cleared.
//   - Accept rules, sampled at the clk edge:
//     wr_ok = winc & ~full; rd_ok = rinc & ~empty.
//   - Write: on wr_ok, mem[wptr[ADDR_WIDTH-1:0]] <= wdata and wptr increments.
//   - Read: on rd_ok, rdata <= mem[rptr[ADDR_WIDTH-1:0]] and rptr increments. rvalid is 1 the
//     next cycle and 0 otherwise. Read latency is 1 cycle. rdata holds its value when no read occurs.
//   - Pointers are ADDR_WIDTH+1 binary and wrap modulo 2*DEPTH.
//     count = wptr - rptr (unsigned, ADDR_WIDTH+1 bits).
//   - Flags are combinational decodes of the registered count. They change the cycle after the
//     accepted operation, with no extra latency.
//   - Simultaneous wr_ok and rd_ok: count unchanged. The read returns the oldest word, never the
//     word being written.
//   - When full, winc with rinc=1: the read is accepted and the write is rejected (full gates).
//   - When empty, winc with rinc=1: the write is accepted and the read is rejected.
//   - Rejected requests have no side effect on pointers, memory or rdata.
// CONFIGURATION
//   - FIFO_ERR_FLAGS_EN defined:
//     overflow sets on winc & full; underflow sets on rinc & empty.
//     Both are sticky until rst_n.
//   - FIFO_ERR_FLAGS_EN undefined:
//     overflow and underflow ports still exist and are tied to 0; no flops are generated.
// STRUCTURE
//   - Package tt_fifo_pkg holds shared constants:
//     FIFO_DW_DEF=4, FIFO_AW_DEF=3, and the localparam function for DEPTH.
//   - Sub-module fifo_ram_2p(DATA_WIDTH, ADDR_WIDTH): synchronous write, asynchronous read array.
//     The top registers its output into rdata.
//   - Pointer, count and flag logic stays in fifo_sync_level.
// TESTING  (defaults DW=4, AW=3, DEPTH=8, AFULL=6, AEMPTY=1)
//   - Reset: assert rst_n=0 mid-stream ->
//     empty=1, full=0, count=0, rvalid=0, rdata=0 without waiting for a clk edge.
//   - Fill: 8 writes of 0x1..0x8 ->
//     count=8, full=1; almost_full rises the cycle count reaches 6.
//     A 9th write is ignored; overflow=1 with the macro, 0 without.
//   - Drain: 8 reads ->
//     rdata = 0x1..0x8 in order, each with rvalid=1 one cycle after rinc.
//     almost_empty rises at count=1; empty=1 after the last read.
//     A 9th read leaves rdata=0x8; underflow=1 with the macro.
//   - Simultaneous: at count=4, 10 cycles of winc=rinc=1 ->
//     count stays 4 and the read order is preserved.
//   - Boundary: at empty, winc=rinc=1 -> count=1, rvalid=0.
//     At full, winc=rinc=1 -> count=7, and the oldest word is returned.
//   - Wrap: 3 fill/drain cycles of 8 words ->
//     pointers wrap past 16 with no data corruption and correct flags.

Source files
------------

// File: rtl/fifo_sync_level_pkg.sv
// tt_fifo_pkg: shared defaults and depth helper for the level-reporting sync FIFO.
package tt_fifo_pkg;
    localparam int FIFO_DW_DEF = 4;
    localparam int FIFO_AW_DEF = 3;
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/fifo_sync_level_if.sv
// fifo_sync_level_if: push/pop handshake, read data and occupancy/status bundle.
interface fifo_sync_level_if
    import tt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DW_DEF,
    parameter int ADDR_WIDTH = FIFO_AW_DEF
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    modport master(
        output winc, wdata, rinc,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave(
        input  winc, wdata, rinc,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_level_ram_2p.sv
// fifo_ram_2p: storage array with synchronous write and asynchronous read.
module fifo_ram_2p #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_sync_level.sv
// fifo_sync_level: single-clock FIFO with count, watermarks and registered read port.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_sync_level
    import tt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DW_DEF,
    parameter int ADDR_WIDTH    = FIFO_AW_DEF,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input logic              clk,
    input logic              rst_n,
    fifo_sync_level_if.slave bus
);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;
    logic [CW-1:0]         r_wptr, r_rptr, w_count;
    logic [DATA_WIDTH-1:0] r_rdata, w_ram_rdata;
    logic                  r_rvalid, w_full, w_empty, w_wr_ok, w_rd_ok;
    assign w_count = r_wptr - r_rptr;
    assign w_full  = w_count == CW'(DEPTH);
    assign w_empty = w_count == '0;
    assign w_wr_ok = bus.winc & ~w_full;
    assign w_rd_ok = bus.rinc & ~w_empty;
    fifo_ram_2p #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (bus.wdata),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_rdata)
    );
    // The async RAM read sees the pre-edge contents, so a same-cycle write never bypasses.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) begin
                r_rptr  <= r_rptr + 1'b1;
                r_rdata <= w_ram_rdata;
            end
            r_rvalid <= w_rd_ok;
        end
`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow, r_underflow;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.winc & w_full)  r_overflow  <= 1'b1;
            if (bus.rinc & w_empty) r_underflow <= 1'b1;
        end
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
    assign bus.rdata        = r_rdata;
    assign bus.rvalid       = r_rvalid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = w_count >= CW'(AFULL_THRESH);
    assign bus.almost_empty = w_count <= CW'(AEMPTY_THRESH);
    assign bus.count        = w_count;
endmodule

// File: tb/tb_fifo_sync_level.sv
// tb_fifo_sync_level: directed tests of fill, drain, simultaneous access, boundaries, wrap and reset.
module tb_fifo_sync_level;
`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] q[$];
    fifo_sync_level_if #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) b ();
    fifo_sync_level #(.DATA_WIDTH(4), .ADDR_WIDTH(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );
    always #5 clk = ~clk;

    task automatic cyc(input logic w, input logic [3:0] d, input logic r);
        b.winc  = w;
        b.wdata = d;
        b.rinc  = r;
        @(posedge clk);
        #1;
        b.winc = 1'b0;
        b.rinc = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({b.empty, b.full, b.almost_empty, b.almost_full, b.count, b.rvalid, b.rdata} !== {4'b1010, 4'd0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL reset_state got e=%b f=%b ae=%b af=%b cnt=%0d rv=%b rd=%h exp e=1 f=0 ae=1 af=0 cnt=0 rv=0 rd=0",
                     b.empty, b.full, b.almost_empty, b.almost_full, b.count, b.rvalid, b.rdata);
        end
        checks++;
        if ({b.overflow, b.underflow} !== 2'b00) begin
            failures++;
            $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", b.overflow, b.underflow);
        end
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 4'(i), 1'b0);
            checks++;
            if (b.count !== 4'(i) || b.almost_full !== (i >= 6) || b.full !== (i == 8) || b.empty !== 1'b0) begin
                failures++;
                $display("FAIL fill i=%0d got cnt=%0d af=%b f=%b e=%b exp cnt=%0d af=%b f=%b e=0",
                         i, b.count, b.almost_full, b.full, b.empty, i, i >= 6, i == 8);
            end
        end
        cyc(1'b1, 4'h9, 1'b0);
        checks++;
        if (b.count !== 4'd8 || b.full !== 1'b1 || b.overflow !== ERR) begin
            failures++;
            $display("FAIL fill_overflow got cnt=%0d f=%b ovf=%b exp cnt=8 f=1 ovf=%b", b.count, b.full, b.overflow, ERR);
        end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 4'h0, 1'b1);
            checks++;
            if (b.rvalid !== 1'b1 || b.rdata !== 4'(i) || b.count !== 4'(8 - i) ||
                b.almost_empty !== (8 - i <= 1) || b.empty !== (i == 8)) begin
                failures++;
                $display("FAIL drain i=%0d got rv=%b rd=%h cnt=%0d ae=%b e=%b exp rv=1 rd=%h cnt=%0d ae=%b e=%b",
                         i, b.rvalid, b.rdata, b.count, b.almost_empty, b.empty, 4'(i), 8 - i, 8 - i <= 1, i == 8);
            end
        end
        cyc(1'b0, 4'h0, 1'b0);
        checks++;
        if (b.rvalid !== 1'b0 || b.rdata !== 4'h8) begin
            failures++;
            $display("FAIL drain_idle got rv=%b rd=%h exp rv=0 rd=8", b.rvalid, b.rdata);
        end
        cyc(1'b0, 4'h0, 1'b1);
        checks++;
        if (b.rvalid !== 1'b0 || b.rdata !== 4'h8 || b.count !== 4'd0 || b.underflow !== ERR) begin
            failures++;
            $display("FAIL drain_underflow got rv=%b rd=%h cnt=%0d unf=%b exp rv=0 rd=8 cnt=0 unf=%b",
                     b.rvalid, b.rdata, b.count, b.underflow, ERR);
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp_d;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(4'hA + i), 1'b0);
            q.push_back(4'(4'hA + i));
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'(i), 1'b1);
            q.push_back(4'(i));
            exp_d = q.pop_front();
            checks++;
            if (b.count !== 4'd4 || b.rvalid !== 1'b1 || b.rdata !== exp_d) begin
                failures++;
                $display("FAIL simul i=%0d got cnt=%0d rv=%b rd=%h exp cnt=4 rv=1 rd=%h", i, b.count, b.rvalid, b.rdata, exp_d);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'h0, 1'b1);
            exp_d = q.pop_front();
            checks++;
            if (b.rdata !== exp_d || b.count !== 4'(3 - i)) begin
                failures++;
                $display("FAIL simul_drain i=%0d got rd=%h cnt=%0d exp rd=%h cnt=%0d", i, b.rdata, b.count, exp_d, 3 - i);
            end
        end
    endtask

    task automatic test_boundary;
        cyc(1'b1, 4'h5, 1'b1);
        checks++;
        if (b.count !== 4'd1 || b.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL bnd_empty got cnt=%0d rv=%b exp cnt=1 rv=0", b.count, b.rvalid);
        end
        for (int i = 0; i < 7; i++) cyc(1'b1, 4'(6 + i), 1'b0);
        checks++;
        if (b.full !== 1'b1) begin
            failures++;
            $display("FAIL bnd_fill got f=%b exp f=1", b.full);
        end
        cyc(1'b1, 4'hF, 1'b1);
        checks++;
        if (b.count !== 4'd7 || b.rvalid !== 1'b1 || b.rdata !== 4'h5) begin
            failures++;
            $display("FAIL bnd_full got cnt=%0d rv=%b rd=%h exp cnt=7 rv=1 rd=5", b.count, b.rvalid, b.rdata);
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 4'h0, 1'b1);
            checks++;
            if (b.rdata !== 4'(6 + i)) begin
                failures++;
                $display("FAIL bnd_drain i=%0d got rd=%h exp rd=%h", i, b.rdata, 4'(6 + i));
            end
        end
        checks++;
        if (b.empty !== 1'b1) begin
            failures++;
            $display("FAIL bnd_empty_end got e=%b exp e=1", b.empty);
        end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) cyc(1'b1, 4'(k * 5 + i), 1'b0);
            checks++;
            if (b.full !== 1'b1 || b.count !== 4'd8 || b.almost_full !== 1'b1) begin
                failures++;
                $display("FAIL wrap_full k=%0d got f=%b cnt=%0d af=%b exp f=1 cnt=8 af=1", k, b.full, b.count, b.almost_full);
            end
            for (int i = 0; i < 8; i++) begin
                cyc(1'b0, 4'h0, 1'b1);
                checks++;
                if (b.rdata !== 4'(k * 5 + i) || b.rvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_data k=%0d i=%0d got rd=%h rv=%b exp rd=%h rv=1", k, i, b.rdata, b.rvalid, 4'(k * 5 + i));
                end
            end
            checks++;
            if (b.empty !== 1'b1 || b.almost_empty !== 1'b1 || b.full !== 1'b0) begin
                failures++;
                $display("FAIL wrap_empty k=%0d got e=%b ae=%b f=%b exp e=1 ae=1 f=0", k, b.empty, b.almost_empty, b.full);
            end
        end
    endtask

    task automatic test_async_reset;
        cyc(1'b1, 4'h3, 1'b0);
        cyc(1'b1, 4'h4, 1'b0);
        cyc(1'b1, 4'h5, 1'b0);
        cyc(1'b0, 4'h0, 1'b1);
        checks++;
        if (b.rvalid !== 1'b1 || b.rdata !== 4'h3 || b.count !== 4'd2) begin
            failures++;
            $display("FAIL areset_pre got rv=%b rd=%h cnt=%0d exp rv=1 rd=3 cnt=2", b.rvalid, b.rdata, b.count);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({b.empty, b.full, b.count, b.rvalid, b.rdata} !== {2'b10, 4'd0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL areset got e=%b f=%b cnt=%0d rv=%b rd=%h exp e=1 f=0 cnt=0 rv=0 rd=0",
                     b.empty, b.full, b.count, b.rvalid, b.rdata);
        end
        checks++;
        if ({b.overflow, b.underflow, b.almost_empty, b.almost_full} !== 4'b0010) begin
            failures++;
            $display("FAIL areset_flags got ovf=%b unf=%b ae=%b af=%b exp 0 0 1 0",
                     b.overflow, b.underflow, b.almost_empty, b.almost_full);
        end
        #2 rst_n = 1'b1;
        cyc(1'b1, 4'h7, 1'b0);
        cyc(1'b0, 4'h0, 1'b1);
        checks++;
        if (b.rdata !== 4'h7 || b.empty !== 1'b1) begin
            failures++;
            $display("FAIL areset_after got rd=%h e=%b exp rd=7 e=1", b.rdata, b.empty);
        end
    endtask

    initial begin
        b.winc  = 1'b0;
        b.rinc  = 1'b0;
        b.wdata = 4'h0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_boundary();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
